alu: RTL and testbench

- Registered WIDTH-bit arithmetic/logic unit; 3-bit `sel` chooses one of eight operations on operands A and B.
- Result and status flags are captured one clock after a valid request.
- Used as the datapath core of the calculator; a controller drives operands and opcode and consumes `result` and flags.

---
 rtl/alu.sv | 88 ++++++++
 tb/tb_alu.sv | 116 +++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered WIDTH-bit ALU: eight operations selected by sel.
// The result and its status flags are captured one clock after an accepted request.
module alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_AND    = 3'b010,
    OP_OR     = 3'b011,
    OP_XOR    = 3'b100,
    OP_NOT    = 3'b101,
    OP_PASS_A = 3'b110,
    OP_PASS_B = 3'b111
  } op_e;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] result_nx;
  logic             carry_nx;
  logic             overflow_nx;

  // Zero-extended subtraction: the top bit comes out as 1 exactly when A < B (borrow).
  always_comb begin
    sum_ext     = {1'b0, A} + {1'b0, B};
    diff_ext    = {1'b0, A} - {1'b0, B};
    result_nx   = '0;
    carry_nx    = 1'b0;
    overflow_nx = 1'b0;
    case (op_e'(sel))
      OP_ADD: begin
        result_nx   = sum_ext[WIDTH-1:0];
        carry_nx    = sum_ext[WIDTH];
        overflow_nx = (A[MSB] == B[MSB]) && (sum_ext[MSB] != A[MSB]);
      end
      OP_SUB: begin
        result_nx   = diff_ext[WIDTH-1:0];
        carry_nx    = diff_ext[WIDTH];
        overflow_nx = (A[MSB] != B[MSB]) && (diff_ext[MSB] != A[MSB]);
      end
      OP_AND:    result_nx = A & B;
      OP_OR:     result_nx = A | B;
      OP_XOR:    result_nx = A ^ B;
      OP_NOT:    result_nx = ~A;
      OP_PASS_A: result_nx = A;
      OP_PASS_B: result_nx = B;
      default:   result_nx = '0;
    endcase
  end

  // Idle cycles keep the last result and flags; only out_valid follows in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= '0;
      out_valid <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= result_nx;
        carry    <= carry_nx;
        overflow <= overflow_nx;
        zero     <= (result_nx == '0);
        negative <= result_nx[MSB];
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed vector bench for alu (WIDTH=4).
// Each check compares the packed word {out_valid, result, carry, overflow, zero, negative}.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] sel;
  logic       in_valid;
  logic [3:0] result;
  logic       out_valid;
  logic       carry;
  logic       overflow;
  logic       zero;
  logic       negative;

  int n_cmp = 0;
  int n_bad = 0;

  alu #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .sel(sel), .in_valid(in_valid),
    .result(result), .out_valid(out_valid), .carry(carry), .overflow(overflow),
    .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] sel;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       c;
    logic       v;
    logic       z;
    logic       n;
  } vec_t;

  vec_t vecs[13];

  // Advance one rising edge and settle a little before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected word layout: {out_valid, result, carry, overflow, zero, negative}.
  task automatic check(input string name, input logic [8:0] exp_word);
    logic [8:0] act;
    act = {out_valid, result, carry, overflow, zero, negative};
    n_cmp++;
    if (act !== exp_word) begin
      n_bad++;
      $display("FAIL %s: got v=%b r=%b c=%b o=%b z=%b n=%b, expected v=%b r=%b c=%b o=%b z=%b n=%b",
               name, act[8], act[7:4], act[3], act[2], act[1], act[0],
               exp_word[8], exp_word[7:4], exp_word[3], exp_word[2], exp_word[1], exp_word[0]);
    end
  endtask

  initial begin
    vecs[0]  = '{"sweep_add",    3'b000, 4'b0101, 4'b0011, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{"sweep_sub",    3'b001, 4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"sweep_and",    3'b010, 4'b0101, 4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"sweep_or",     3'b011, 4'b0101, 4'b0011, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{"sweep_xor",    3'b100, 4'b0101, 4'b0011, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{"sweep_not",    3'b101, 4'b0101, 4'b0011, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{"sweep_pass_a", 3'b110, 4'b0101, 4'b0011, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"sweep_pass_b", 3'b111, 4'b0101, 4'b0011, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{"add_carry",    3'b000, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{"add_ovf",      3'b000, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{"sub_borrow",   3'b001, 4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{"sub_ovf",      3'b001, 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{"sub_zero",     3'b001, 4'b0110, 4'b0110, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset held with a live request: reset must win.
    rst_n = 1'b0; in_valid = 1'b1; A = 4'd5; B = 4'd3; sel = 3'b000;
    step(); check("reset_c1", 9'b0);
    step(); check("reset_c2", 9'b0);
    rst_n = 1'b1; in_valid = 1'b0;
    step(); check("post_reset_idle1", 9'b0);
    step(); check("post_reset_idle2", 9'b0);

    // Back-to-back table: one request per cycle.
    in_valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      sel = vecs[i].sel; A = vecs[i].a; B = vecs[i].b;
      step();
      check(vecs[i].name, {1'b1, vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n});
    end

    // Hold: idle cycles keep the result while inputs wander.
    sel = 3'b000; A = 4'd2; B = 4'd2; in_valid = 1'b1;
    step(); check("hold_accept", 9'b1_0100_0000);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      A = 4'(4'd9 + k); B = 4'(4'd7 - k); sel = 3'(k + 1);
      step(); check($sformatf("hold_idle%0d", k), 9'b0_0100_0000);
    end

    // Mid-stream reset discards the in-flight request.
    in_valid = 1'b1; sel = 3'b000; A = 4'd1; B = 4'd1;
    step(); check("mid_first", 9'b1_0010_0000);
    rst_n = 1'b0; A = 4'd7; B = 4'd7;
    step(); check("mid_reset", 9'b0);
    rst_n = 1'b1; sel = 3'b100; A = 4'b1100; B = 4'b1010;
    step(); check("mid_xor_after", 9'b1_0110_0000);
    in_valid = 1'b0;
    step(); check("mid_xor_idle", 9'b0_0110_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
